// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter and the other AXI blocks
// (VGA fetcher, DMA): FSM encoding and AXI burst/response constants.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;

  // Width of the starvation counter; holds MAX_CONSEC up to 15.
  localparam int CONSEC_W = 4;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R). The master modport is the side that
// issues AR and accepts R; the slave modport is the side that accepts AR.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) ();

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

endinterface

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Arbitration decision for the two read requesters. Port 0 (VGA) wins
// contention until port 1 has watched MAX_CONSEC port-0 grants go by.
module axi_rr_pick
  import axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic                req0,
  input  logic                req1,
  input  logic [CONSEC_W-1:0] consec_cnt,
  output logic                grant_vld,
  output logic                grant
);

  localparam logic [CONSEC_W-1:0] MAX_CNT = CONSEC_W'(MAX_CONSEC);

  // Pick a port whenever anyone asks; port 1 only on its own or when starved.
  always_comb begin
    grant_vld = req0 | req1;
    grant     = 1'b0;
    if (req1 && (!req0 || (consec_cnt == MAX_CNT))) grant = 1'b1;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-to-one AXI4 read arbiter: VGA line fetcher on port 0, CPU/DMA on
// port 1, one burst outstanding, grant held from AR handshake to rlast.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int MAX_CONSEC = 4
) (
  input  logic             clock,
  input  logic             resetn,
  axi_rd_arbiter_if.slave  io_slave0,
  axi_rd_arbiter_if.slave  io_slave1,
  axi_rd_arbiter_if.master io_master
);

  localparam logic [CONSEC_W-1:0] MAX_CNT = CONSEC_W'(MAX_CONSEC);

  arb_state_t          state, state_nxt;
  logic                grant, grant_nxt;
  logic [CONSEC_W-1:0] consec_cnt, consec_nxt;
  logic                pick_vld, pick_grant;
  logic                in_addr, in_data;

  logic [ADDR_W-1:0]   araddr_mux;
  logic [ID_W-1:0]     arid_mux;
  logic [DATA_W-1:0]   rdata_bus;
  logic [ID_W-1:0]     rid_bus;

  axi_rr_pick #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_pick (
    .req0       (io_slave0.arvalid),
    .req1       (io_slave1.arvalid),
    .consec_cnt (consec_cnt),
    .grant_vld  (pick_vld),
    .grant      (pick_grant)
  );

  // Control state; a mid-burst reset simply abandons the burst.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      consec_cnt <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      consec_cnt <= consec_nxt;
    end
  end

  // Next state: arbitrate in IDLE, wait for AR handshake, then for rlast.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    consec_nxt = consec_cnt;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          state_nxt = S_ADDR;
          grant_nxt = pick_grant;
          if (pick_grant) begin
            consec_nxt = '0;
          end else if (io_slave1.arvalid) begin
            // Port 1 is being passed over: count it, saturating.
            consec_nxt = (consec_cnt >= MAX_CNT) ? MAX_CNT : consec_cnt + 1'b1;
          end else begin
            consec_nxt = '0;
          end
        end
      end
      S_ADDR: begin
        if (io_master.arready) state_nxt = S_DATA;
      end
      S_DATA: begin
        // No beat counter: the burst ends on the rlast handshake only.
        if (io_master.rvalid && io_master.rready && io_master.rlast) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_addr = (state == S_ADDR);
  assign in_data = (state == S_DATA);

  // AR path: payload muxed on the registered grant, handshake gated by state.
  assign araddr_mux        = grant ? io_slave1.araddr : io_slave0.araddr;
  assign arid_mux          = grant ? io_slave1.arid   : io_slave0.arid;
  assign io_master.arvalid = in_addr;
  assign io_master.araddr  = araddr_mux;
  assign io_master.arid    = arid_mux;
  assign io_master.arlen   = grant ? io_slave1.arlen   : io_slave0.arlen;
  assign io_master.arsize  = grant ? io_slave1.arsize  : io_slave0.arsize;
  assign io_master.arburst = grant ? io_slave1.arburst : io_slave0.arburst;
  assign io_slave0.arready = in_addr && !grant && io_master.arready;
  assign io_slave1.arready = in_addr &&  grant && io_master.arready;

  // R path: payload fans out to both ports, only the granted one sees rvalid.
  assign rdata_bus         = io_master.rdata;
  assign rid_bus           = io_master.rid;
  assign io_master.rready  = in_data && (grant ? io_slave1.rready : io_slave0.rready);
  assign io_slave0.rvalid  = in_data && !grant && io_master.rvalid;
  assign io_slave1.rvalid  = in_data &&  grant && io_master.rvalid;
  assign io_slave0.rdata   = rdata_bus;
  assign io_slave1.rdata   = rdata_bus;
  assign io_slave0.rid     = rid_bus;
  assign io_slave1.rid     = rid_bus;
  assign io_slave0.rresp   = io_master.rresp;
  assign io_slave1.rresp   = io_master.rresp;
  assign io_slave0.rlast   = io_master.rlast;
  assign io_slave1.rlast   = io_master.rlast;

endmodule
